csr_init_seq: RTL

- CSR-bus master that replays a parameter-defined table of register writes after reset, with a programmable delay after each write.
- Typical use: power-up ordering of GPIO output-enable and output registers.
- Sits between the host CSR port (I2C/SPI slave) and the peripheral CSR bus.
- Owns the bus while the sequence runs, then hands it transparently to the host.

---
 rtl/csr_init_seq_pkg.sv | 22 ++
 rtl/csr_init_seq_tick.sv | 26 ++
 rtl/csr_init_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/csr_init_seq_pkg.sv
// csr_init_seq shared definitions: FSM encodings, table entry layout and
// status register bit positions.
package csr_init_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int ENTRY_W  = 24;
  localparam int ADDR_LSB = 16;
  localparam int ADDR_W   = 5;
  localparam int DATA_LSB = 8;
  localparam int DATA_W   = 8;
  localparam int DLY_LSB  = 0;
  localparam int DLY_W    = 8;

  localparam int ST_BUSY = 7;
  localparam int ST_DONE = 6;
  localparam int ST_DROP = 5;

endpackage

// File: rtl/csr_init_seq_tick.sv
// tick_prescaler: modulo-PRESCALE counter, one-cycle tick per wrap,
// restartable from zero via clear.
module tick_prescaler #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/csr_init_seq.sv
// csr_init_seq: replays a table of CSR writes after reset, then hands the
// bus to the host. Optional status register: CSR_INIT_SEQ_STATUS_EN.
module csr_init_seq
  import csr_init_seq_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter logic [((NUM_STEPS > 0) ? NUM_STEPS : 1)*24-1:0]
    STEP_TABLE = '0,
  parameter int PRESCALE = 1024,
  parameter bit AUTO_START = 1'b1,
  parameter logic [4:0] STATUS_ADDR = 5'h1f
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] host_a,
  input  logic [7:0] host_di,
  input  logic       host_we,
  output logic [7:0] host_do,
  output logic [4:0] csr_a,
  output logic [7:0] csr_di,
  output logic       csr_we,
  input  logic [7:0] csr_do,
  output logic       busy,
  output logic       done,
  output logic       host_drop
);

  localparam logic [1:0] RST_STATE =
    (NUM_STEPS == 0) ? S_DONE :
    (AUTO_START ? S_WRITE : S_IDLE);

  logic [1:0] state;
  logic [3:0] step;
  logic [7:0] dly_cnt;
  logic [4:0] e_addr;
  logic [7:0] e_data;
  logic [7:0] e_dly;
  logic       last;
  logic       tick;
  logic       clear;
  logic       st_hit;
  logic       st_clr;
  logic [7:0] status;

  always_comb begin
    e_addr = '0;
    e_data = '0;
    e_dly  = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step == 4'(i)) begin
        e_addr = STEP_TABLE[ENTRY_W*i+ADDR_LSB +: ADDR_W];
        e_data = STEP_TABLE[ENTRY_W*i+DATA_LSB +: DATA_W];
        e_dly  = STEP_TABLE[ENTRY_W*i+DLY_LSB +: DLY_W];
      end
    end
  end

  assign busy  = (state == S_WRITE) || (state == S_DELAY);
  assign last  = (step == 4'(NUM_STEPS - 1));
  assign clear = (state == S_WRITE) && (e_dly != 8'd0);

  assign status = {busy, done, host_drop, 1'b0, step};

`ifdef CSR_INIT_SEQ_STATUS_EN
  assign st_hit = (host_a == STATUS_ADDR);
  assign st_clr = st_hit && host_we && host_di[ST_DROP];
`else
  logic unused_status;
  assign unused_status = ^{STATUS_ADDR, status};
  assign st_hit = 1'b0;
  assign st_clr = 1'b0;
`endif

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // Host owns the bus unless the sequence runs; reset masks any strobe.
  always_comb begin
    csr_a   = host_a;
    csr_di  = host_di;
    csr_we  = host_we && !st_hit;
    host_do = csr_do;
    if (busy) begin
      csr_a   = e_addr;
      csr_di  = e_data;
      csr_we  = (state == S_WRITE);
      host_do = 8'h00;
    end
    if (st_hit)
      host_do = status;
    if (rst)
      csr_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      step      <= '0;
      dly_cnt   <= '0;
      done      <= (NUM_STEPS == 0);
      host_drop <= 1'b0;
    end else begin
      if (st_clr)
        host_drop <= 1'b0;
      else if (busy && host_we)
        host_drop <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && (NUM_STEPS != 0)) begin
            state <= S_WRITE;
            step  <= '0;
          end
        end
        S_WRITE: begin
          if (e_dly != 8'd0) begin
            state   <= S_DELAY;
            dly_cnt <= e_dly;
          end else if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            step <= step + 4'd1;
          end
        end
        S_DELAY: begin
          if (tick) begin
            dly_cnt <= dly_cnt - 8'd1;
            if (dly_cnt == 8'd1) begin
              if (last) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_WRITE;
                step  <= step + 4'd1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
